// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: bus widths, bdi/bdo segment type codes and the
// arbiter state encoding used by ascon_arbiter.
package ascon_pkg;

    localparam int CCW  = 32;
    localparam int CCSW = 32;

    // bdi/bdo segment type codes
    localparam logic [3:0] D_NULL  = 4'd0;
    localparam logic [3:0] D_NONCE = 4'd1;
    localparam logic [3:0] D_AD    = 4'd2;
    localparam logic [3:0] D_MSG   = 4'd3;
    localparam logic [3:0] D_TAG   = 4'd4;
    localparam logic [3:0] D_HASH  = 4'd5;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_AUTH
    } arb_state_t;

    // Output segment types whose last word ends an operation
    function automatic logic is_final_type(input logic [3:0] t);
        return (t == D_TAG) || (t == D_HASH);
    endfunction

endpackage

// File: rtl/ascon_rr_arb.sv
// Combinational round-robin pick: the first pending requester strictly after
// the pointer (wrapping) wins, so the last-granted requester goes last.
module ascon_rr_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [1:0]         ptr,
    output logic [1:0]         grant,
    output logic               any
);

    // Scan distances from far to near so the nearest pending requester wins
    always_comb begin
        grant = 2'd0;
        any   = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pending[i] && (i == ((int'(ptr) + k) % NUM_REQ))) begin
                    grant = i[1:0];
                    any   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ascon_arbiter.sv
// Shares one ascon_core between NUM_REQ requesters. A grant is locked for a
// whole operation and released when the final tag/hash word is delivered or
// when the tag-verify result has been handed to the requester.
// Optional feature: define ASCON_ARB_STATS_EN to add per-requester
// completed-operation counters on output op_count.
module ascon_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CCW     = ascon_pkg::CCW,
    parameter int CCSW    = ascon_pkg::CCSW
) (
    input  logic                    clk,
    input  logic                    rst,
    // requester side
    input  logic [NUM_REQ*CCSW-1:0] req_key,
    input  logic [NUM_REQ-1:0]      req_key_valid,
    output logic [NUM_REQ-1:0]      req_key_ready,
    input  logic [NUM_REQ*CCW-1:0]  req_bdi,
    input  logic [NUM_REQ-1:0]      req_bdi_valid,
    output logic [NUM_REQ-1:0]      req_bdi_ready,
    input  logic [NUM_REQ*4-1:0]    req_bdi_type,
    input  logic [NUM_REQ-1:0]      req_bdi_eot,
    input  logic [NUM_REQ-1:0]      req_bdi_eoi,
    input  logic [NUM_REQ-1:0]      req_decrypt,
    input  logic [NUM_REQ-1:0]      req_hash,
    output logic [NUM_REQ*CCW-1:0]  req_bdo,
    output logic [NUM_REQ-1:0]      req_bdo_valid,
    input  logic [NUM_REQ-1:0]      req_bdo_ready,
    output logic [NUM_REQ*4-1:0]    req_bdo_type,
    output logic [NUM_REQ-1:0]      req_bdo_eot,
    output logic [NUM_REQ-1:0]      req_auth,
    output logic [NUM_REQ-1:0]      req_auth_valid,
    input  logic [NUM_REQ-1:0]      req_auth_ready,
    // core side
    output logic [CCSW-1:0]         core_key,
    output logic                    core_key_valid,
    input  logic                    core_key_ready,
    output logic [CCW-1:0]          core_bdi,
    output logic                    core_bdi_valid,
    input  logic                    core_bdi_ready,
    output logic [3:0]              core_bdi_type,
    output logic                    core_bdi_eot,
    output logic                    core_bdi_eoi,
    output logic                    core_decrypt,
    output logic                    core_hash,
    input  logic [CCW-1:0]          core_bdo,
    input  logic                    core_bdo_valid,
    output logic                    core_bdo_ready,
    input  logic [3:0]              core_bdo_type,
    input  logic                    core_bdo_eot,
    input  logic                    core_auth,
    input  logic                    core_auth_valid,
    output logic                    core_auth_ready,
    // status
    output logic [1:0]              grant_id,
`ifdef ASCON_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]   op_count,
`endif
    output logic                    busy
);

    import ascon_pkg::*;

    arb_state_t         state_q, state_d;
    logic [1:0]         grant_q;
    logic [1:0]         ptr_q;
    logic               auth_armed_q;
    logic               auth_q;

    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] gsel;
    logic [1:0]         pick;
    logic               pick_any;

    logic               in_idle, in_busy, in_auth;
    logic               g_key_valid, g_bdi_valid, g_bdo_ready, g_auth_ready;
    logic               hs_in, done_tag, take_auth, done_auth;

    assign pending = req_key_valid | req_bdi_valid;

    ascon_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr (
        .pending (pending),
        .ptr     (ptr_q),
        .grant   (pick),
        .any     (pick_any)
    );

    assign in_idle = (state_q == ARB_IDLE);
    assign in_busy = (state_q == ARB_BUSY);
    assign in_auth = (state_q == ARB_AUTH);

    // Decode the held grant and route the granted requester's inputs to the core
    always_comb begin
        gsel          = '0;
        core_key      = '0;
        core_bdi      = '0;
        core_bdi_type = 4'd0;
        core_bdi_eot  = 1'b0;
        core_bdi_eoi  = 1'b0;
        core_decrypt  = 1'b0;
        core_hash     = 1'b0;
        g_key_valid   = 1'b0;
        g_bdi_valid   = 1'b0;
        g_bdo_ready   = 1'b0;
        g_auth_ready  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == i[1:0]) begin
                gsel[i]       = 1'b1;
                core_key      = req_key[i*CCSW +: CCSW];
                core_bdi      = req_bdi[i*CCW +: CCW];
                core_bdi_type = req_bdi_type[i*4 +: 4];
                core_bdi_eot  = req_bdi_eot[i];
                core_bdi_eoi  = req_bdi_eoi[i];
                core_decrypt  = req_decrypt[i];
                core_hash     = req_hash[i];
                g_key_valid   = req_key_valid[i];
                g_bdi_valid   = req_bdi_valid[i];
                g_bdo_ready   = req_bdo_ready[i];
                g_auth_ready  = req_auth_ready[i];
            end
        end
    end

    // Operation boundary events seen while a grant is held
    assign hs_in     = in_busy & ((g_key_valid & core_key_ready) | (g_bdi_valid & core_bdi_ready));
    assign done_tag  = in_busy & core_bdo_valid & g_bdo_ready & core_bdo_eot
                     & is_final_type(core_bdo_type);
    assign take_auth = in_busy & ~done_tag & auth_armed_q & core_auth_valid;
    assign done_auth = in_auth & g_auth_ready;

    // Next-state and core-facing handshake gating
    always_comb begin
        state_d         = state_q;
        core_key_valid  = 1'b0;
        core_bdi_valid  = 1'b0;
        core_bdo_ready  = 1'b0;
        core_auth_ready = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) state_d = ARB_BUSY;
            end
            ARB_BUSY: begin
                core_key_valid = g_key_valid;
                core_bdi_valid = g_bdi_valid;
                core_bdo_ready = g_bdo_ready;
                if (done_tag)       state_d = ARB_IDLE;
                else if (take_auth) state_d = ARB_AUTH;
            end
            ARB_AUTH: begin
                core_auth_ready = 1'b1;
                if (g_auth_ready) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Requester-facing outputs; only the granted requester sees ready/valid
    assign req_key_ready  = in_busy ? (gsel & {NUM_REQ{core_key_ready}}) : '0;
    assign req_bdi_ready  = in_busy ? (gsel & {NUM_REQ{core_bdi_ready}}) : '0;
    assign req_bdo_valid  = in_busy ? (gsel & {NUM_REQ{core_bdo_valid}}) : '0;
    assign req_bdo        = {NUM_REQ{core_bdo}};
    assign req_bdo_type   = {NUM_REQ{core_bdo_type}};
    assign req_bdo_eot    = {NUM_REQ{core_bdo_eot}};
    assign req_auth_valid = in_auth ? gsel : '0;
    assign req_auth       = in_auth ? (gsel & {NUM_REQ{auth_q}}) : '0;

    assign grant_id = grant_q;
    assign busy     = ~in_idle;

    // Control state: FSM, grant, round-robin pointer and stale-auth mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= 2'd0;
            ptr_q        <= 2'(NUM_REQ - 1);
            auth_armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_idle && pick_any) begin
                grant_q      <= pick;
                ptr_q        <= pick;
                auth_armed_q <= 1'b0;
            end else if (hs_in) begin
                auth_armed_q <= 1'b1;
            end
        end
    end

    // Capture the tag-verify result; only observable in AUTH so no reset
    always_ff @(posedge clk) begin
        if (take_auth) auth_q <= core_auth;
    end

`ifdef ASCON_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    // Saturating per-requester count of completed operations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((done_tag || done_auth) && gsel[i] && (cnt_q[i] != 16'hFFFF))
                    cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    // Flatten counters onto the status port
    always_comb begin
        op_count = '0;
        for (int i = 0; i < NUM_REQ; i++) op_count[i*16 +: 16] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_ascon_arbiter.sv
// Directed bench for ascon_arbiter with NUM_REQ = 2; the bench plays both the
// requesters and the shared core. Covers op_count when ASCON_ARB_STATS_EN is set.
module tb_ascon_arbiter;
    import ascon_pkg::*;

    localparam int N  = 2;
    localparam int W  = 32;
    localparam int KW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*KW-1:0] req_key = '0;
    logic [N-1:0]    req_key_valid = '0;
    logic [N-1:0]    req_key_ready;
    logic [N*W-1:0]  req_bdi = '0;
    logic [N-1:0]    req_bdi_valid = '0;
    logic [N-1:0]    req_bdi_ready;
    logic [N*4-1:0]  req_bdi_type = '0;
    logic [N-1:0]    req_bdi_eot = '0;
    logic [N-1:0]    req_bdi_eoi = '0;
    logic [N-1:0]    req_decrypt = '0;
    logic [N-1:0]    req_hash = '0;
    logic [N*W-1:0]  req_bdo;
    logic [N-1:0]    req_bdo_valid;
    logic [N-1:0]    req_bdo_ready = '0;
    logic [N*4-1:0]  req_bdo_type;
    logic [N-1:0]    req_bdo_eot;
    logic [N-1:0]    req_auth;
    logic [N-1:0]    req_auth_valid;
    logic [N-1:0]    req_auth_ready = '0;
    logic [KW-1:0]   core_key;
    logic            core_key_valid;
    logic            core_key_ready = 1'b1;
    logic [W-1:0]    core_bdi;
    logic            core_bdi_valid;
    logic            core_bdi_ready = 1'b1;
    logic [3:0]      core_bdi_type;
    logic            core_bdi_eot;
    logic            core_bdi_eoi;
    logic            core_decrypt;
    logic            core_hash;
    logic [W-1:0]    core_bdo = '0;
    logic            core_bdo_valid = 1'b0;
    logic            core_bdo_ready;
    logic [3:0]      core_bdo_type = 4'd0;
    logic            core_bdo_eot = 1'b0;
    logic            core_auth = 1'b0;
    logic            core_auth_valid = 1'b0;
    logic            core_auth_ready;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef ASCON_ARB_STATS_EN
    logic [N*16-1:0] op_count;
`endif

    int checks = 0;
    int errors = 0;

    ascon_arbiter #(.NUM_REQ(N), .CCW(W), .CCSW(KW)) dut (
        .clk(clk), .rst(rst),
        .req_key(req_key), .req_key_valid(req_key_valid), .req_key_ready(req_key_ready),
        .req_bdi(req_bdi), .req_bdi_valid(req_bdi_valid), .req_bdi_ready(req_bdi_ready),
        .req_bdi_type(req_bdi_type), .req_bdi_eot(req_bdi_eot), .req_bdi_eoi(req_bdi_eoi),
        .req_decrypt(req_decrypt), .req_hash(req_hash),
        .req_bdo(req_bdo), .req_bdo_valid(req_bdo_valid), .req_bdo_ready(req_bdo_ready),
        .req_bdo_type(req_bdo_type), .req_bdo_eot(req_bdo_eot),
        .req_auth(req_auth), .req_auth_valid(req_auth_valid), .req_auth_ready(req_auth_ready),
        .core_key(core_key), .core_key_valid(core_key_valid), .core_key_ready(core_key_ready),
        .core_bdi(core_bdi), .core_bdi_valid(core_bdi_valid), .core_bdi_ready(core_bdi_ready),
        .core_bdi_type(core_bdi_type), .core_bdi_eot(core_bdi_eot), .core_bdi_eoi(core_bdi_eoi),
        .core_decrypt(core_decrypt), .core_hash(core_hash),
        .core_bdo(core_bdo), .core_bdo_valid(core_bdo_valid), .core_bdo_ready(core_bdo_ready),
        .core_bdo_type(core_bdo_type), .core_bdo_eot(core_bdo_eot),
        .core_auth(core_auth), .core_auth_valid(core_auth_valid), .core_auth_ready(core_auth_ready),
        .grant_id(grant_id),
`ifdef ASCON_ARB_STATS_EN
        .op_count(op_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core emits the final tag word; requester r accepts it
    task automatic core_tag(input int r);
        core_bdo       = 32'h7A67_0000;
        core_bdo_type  = D_TAG;
        core_bdo_eot   = 1'b1;
        core_bdo_valid = 1'b1;
        req_bdo_ready[r] = 1'b1;
    endtask

    task automatic core_idle();
        core_bdo_valid = 1'b0;
        core_bdo_eot   = 1'b0;
        core_bdo_type  = D_NULL;
        req_bdo_ready  = '0;
    endtask

    // One nonce-then-tag operation on requester r, grant wait bounded
    task automatic quick_op(input int r);
        req_bdi_type[r*4 +: 4] = D_NONCE;
        req_bdi_valid[r] = 1'b1;
        for (int c = 0; c < 8 && !(busy === 1'b1 && grant_id === r[1:0]); c++) tick();
        chk("qop_grant", {63'd0, (busy === 1'b1 && grant_id === r[1:0])}, 64'd1);
        req_bdi_valid[r] = 1'b0;
        core_tag(r);
        tick();
        chk("qop_release", busy, 0);
        core_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        core_auth_valid = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_key_ready", req_key_ready, 0);
        chk("rst_bdi_ready", req_bdi_ready, 0);
        chk("rst_bdo_valid", req_bdo_valid, 0);
        chk("rst_auth_valid", req_auth_valid, 0);
        chk("rst_core_kv", core_key_valid, 0);
        chk("rst_core_bv", core_bdi_valid, 0);
        chk("rst_core_bdo_rdy", core_bdo_ready, 0);
        chk("rst_core_auth_rdy", core_auth_ready, 0);
        tick();
        tick();
        rst = 1'b0;

        // ---------------- 1: AEAD encrypt on req0 ----------------
        req_key[31:0] = 32'h0123_4567;
        req_key_valid[0] = 1'b1;
        #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_core_kv", core_key_valid, 0);
        tick();
        chk("t1_busy", busy, 1);
        chk("t1_grant", grant_id, 0);
        chk("t1_core_key", core_key, 64'h0123_4567);
        chk("t1_core_kv", core_key_valid, 1);
        chk("t1_key_ready", req_key_ready, 2'b01);
        chk("t1_stale_auth", req_auth_valid, 0);
        tick();
        chk("t1_stale_masked_busy", busy, 1);
        chk("t1_stale_masked_av", req_auth_valid, 0);
        core_auth_valid = 1'b0;
        req_key_valid = '0;
        req_bdi[31:0] = 32'hAAAA_0001;
        req_bdi_type[3:0] = D_NONCE;
        req_bdi_valid[0] = 1'b1;
        #1;
        chk("t1_core_bdi", core_bdi, 64'hAAAA_0001);
        chk("t1_core_bdi_type", core_bdi_type, D_NONCE);
        chk("t1_bdi_ready", req_bdi_ready, 2'b01);
        tick();
        req_bdi[31:0] = 32'hAD00_0001; req_bdi_type[3:0] = D_AD; req_bdi_eot[0] = 1'b1;
        tick();
        req_bdi[31:0] = 32'h5000_0001; req_bdi_type[3:0] = D_MSG; req_bdi_eot[0] = 1'b0;
        tick();
        req_bdi[31:0] = 32'h5000_0002; req_bdi_eot[0] = 1'b1; req_bdi_eoi[0] = 1'b1;
        #1;
        chk("t1_core_eoi", core_bdi_eoi, 1);
        tick();
        req_bdi_valid = '0; req_bdi_eot = '0; req_bdi_eoi = '0;
        core_bdo = 32'hC000_0001; core_bdo_type = D_MSG; core_bdo_valid = 1'b1;
        req_bdo_ready[0] = 1'b1;
        #1;
        chk("t1_req_bdo", req_bdo[31:0], 64'hC000_0001);
        chk("t1_bdo_valid", req_bdo_valid, 2'b01);
        chk("t1_core_bdo_rdy", core_bdo_ready, 1);
        tick();
        core_bdo = 32'hC000_0002; core_bdo_eot = 1'b1;
        tick();
        chk("t1_msg_eot_holds", busy, 1);
        core_bdo_type = D_TAG; core_bdo_eot = 1'b1; req_bdo_ready = '0;
        #1;
        chk("t1_tag_stalled_rdy", core_bdo_ready, 0);
        tick();
        chk("t1_tag_stalled_busy", busy, 1);
        req_bdo_ready[0] = 1'b1;
        tick();
        chk("t1_release", busy, 0);
        core_idle();

        // ---------------- 2: round-robin ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_bdi[31:0] = 32'h1111_1111; req_bdi[63:32] = 32'h2222_2222;
        req_bdi_type = {D_NONCE, D_NONCE};
        req_bdi_valid = 2'b11;
        tick();
        chk("t2_first_grant", grant_id, 0);
        chk("t2_core_bdi0", core_bdi, 64'h1111_1111);
        chk("t2_bdi_ready0", req_bdi_ready, 2'b01);
        core_tag(0);
        req_bdo_ready = 2'b11;
        tick();
        chk("t2_idle_gap", busy, 0);
        core_idle();
        tick();
        chk("t2_second_grant", grant_id, 1);
        chk("t2_core_bdi1", core_bdi, 64'h2222_2222);
        chk("t2_bdi_ready1", req_bdi_ready, 2'b10);
        core_tag(1);
        #1;
        chk("t2_bdo_valid1", req_bdo_valid, 2'b10);
        tick();
        core_idle();
        tick();
        chk("t2_third_grant", grant_id, 0);
        req_bdi_valid = '0;
        core_tag(0);
        tick();
        chk("t2_release", busy, 0);
        core_idle();

        // ---------------- 3: decrypt with auth on req1 ----------------
        req_bdi[63:32] = 32'h3333_0001; req_bdi_type[7:4] = D_NONCE;
        req_decrypt[1] = 1'b1; req_bdi_valid[1] = 1'b1;
        tick();
        chk("t3_grant", grant_id, 1);
        chk("t3_core_decrypt", core_decrypt, 1);
        tick();
        req_bdi_valid = '0;
        core_auth = 1'b1; core_auth_valid = 1'b1;
        #1;
        chk("t3_pre_auth", req_auth_valid, 0);
        tick();
        core_auth = 1'b0;
        #1;
        chk("t3_auth_valid", req_auth_valid, 2'b10);
        chk("t3_auth", req_auth, 2'b10);
        chk("t3_core_auth_rdy", core_auth_ready, 1);
        chk("t3_busy", busy, 1);
        chk("t3_bdi_ready", req_bdi_ready, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_hold_av", req_auth_valid, 2'b10);
            chk("t3_hold_auth", req_auth, 2'b10);
        end
        req_auth_ready = 2'b11;
        tick();
        chk("t3_release_busy", busy, 0);
        chk("t3_release_av", req_auth_valid, 0);
        req_auth_ready = '0; req_decrypt = '0;
        req_key_valid[0] = 1'b1;
        tick();
        chk("t3_enc_grant", grant_id, 0);
        chk("t3_enc_no_auth", req_auth_valid, 0);
        tick();
        chk("t3_enc_stale_masked", req_auth_valid, 0);
        chk("t3_enc_busy", busy, 1);
        core_auth_valid = 1'b0; req_key_valid = '0;
        core_tag(0);
        tick();
        chk("t3_enc_release", busy, 0);
        core_idle();

        // ---------------- 4: hash on req0 ----------------
        req_bdi[31:0] = 32'h4A54_0001; req_bdi_type[3:0] = D_AD;
        req_hash[0] = 1'b1; req_bdi_valid[0] = 1'b1;
        tick();
        chk("t4_grant", grant_id, 0);
        chk("t4_core_hash", core_hash, 1);
        chk("t4_core_type", core_bdi_type, D_AD);
        req_bdi_valid = '0;
        core_bdo = 32'hF00D_0001; core_bdo_type = D_HASH; core_bdo_valid = 1'b1;
        req_bdo_ready[0] = 1'b1;
        #1;
        chk("t4_bdo_valid", req_bdo_valid, 2'b01);
        tick();
        chk("t4_hold", busy, 1);
        core_bdo_eot = 1'b1;
        #1;
        chk("t4_bdo_valid_eot", req_bdo_valid, 2'b01);
        tick();
        chk("t4_release", busy, 0);
        chk("t4_idle_bdo_gated", req_bdo_valid, 0);
        core_idle();
        req_hash = '0;

        // ---------------- 5: async reset mid-op ----------------
        req_bdi[63:32] = 32'h5555_0001; req_bdi_type[7:4] = D_NONCE; req_bdi_valid[1] = 1'b1;
        tick();
        chk("t5_grant", grant_id, 1);
        req_bdi_type[7:4] = D_MSG;
        core_bdo_valid = 1'b1; core_bdo_type = D_MSG; req_bdo_ready[1] = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_bdi_ready", req_bdi_ready, 0);
        chk("t5_rst_bdo_valid", req_bdo_valid, 0);
        chk("t5_rst_core_bv", core_bdi_valid, 0);
        chk("t5_rst_core_bdo_rdy", core_bdo_ready, 0);
        chk("t5_rst_grant", grant_id, 0);
        tick();
        tick();
        rst = 1'b0;
        core_idle();
        req_bdi_type[7:4] = D_NONCE;
        tick();
        chk("t5_fresh_grant", grant_id, 1);
        chk("t5_fresh_busy", busy, 1);
        req_bdi_valid = '0;
        core_tag(1);
        #1;
        chk("t5_fresh_bdo", req_bdo_valid, 2'b10);
        tick();
        chk("t5_fresh_release", busy, 0);
        core_idle();

        // ---------------- 6: operation counters ----------------
        quick_op(0);
        quick_op(0);
        quick_op(0);
`ifdef ASCON_ARB_STATS_EN
        chk("t6_op_count", op_count, {16'd1, 16'd3});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
